// File: rtl/regdump_pkg.sv
// Shared widths, FSM state encoding and range helper for the register-file dump reader.
package regdump_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOLD,
    ST_READ,
    ST_SEND,
    ST_DONE
  } state_e;

  // Inclusive word count of a range that may wrap through the top index back to zero.
  function automatic logic [ADDR_W:0] wordCount(input logic [ADDR_W-1:0] first,
                                                input logic [ADDR_W-1:0] last);
    logic [ADDR_W-1:0] span;
    span = last - first;
    return {1'b0, span} + (ADDR_W+1)'(1);
  endfunction

endpackage

// File: rtl/regfile_dump.sv
// Walks a wrapping register range through a spare read port under a pipeline hold,
// streaming {index, value} words over a valid/ready interface.
module regfile_dump
  import regdump_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic              hold_req,
  input  logic              hold_ack,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cur_q, cur_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cur_q       <= '0;
      last_q      <= '0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      last_q      <= last_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    last_d      = last_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;

    // Abort outranks everything outside IDLE, including a handshake in the same cycle.
    if (abort && (state_q != ST_IDLE)) begin
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && !abort) begin
            cur_d   = first_addr;
            last_d  = last_addr;
            state_d = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (hold_ack) state_d = ST_READ;
        end
        ST_READ: begin
          out_data_d  = rd_data;
          out_addr_d  = cur_q;
          out_last_d  = (cur_q == last_q);
          out_valid_d = 1'b1;
          state_d     = ST_SEND;
        end
        ST_SEND: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            if (out_last_q) begin
              state_d = ST_DONE;
            end else begin
              cur_d   = cur_q + ADDR_W'(1);
              state_d = ST_READ;
            end
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // The hold spans HOLD through the final SEND and is already released in DONE.
  assign hold_req  = (state_q == ST_HOLD) || (state_q == ST_READ) || (state_q == ST_SEND);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE) && !abort;
  assign rd_addr   = cur_q;
  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_regfile_dump.sv
// Directed self-checking bench for regfile_dump with a behavioural register-file model.
module tb_regfile_dump;
  import regdump_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] first_addr;
  logic [ADDR_W-1:0] last_addr;
  logic              hold_req;
  logic              hold_ack;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              busy;
  logic              done;

  logic [DATA_W-1:0] regs [32];
  int compared   = 0;
  int mismatched = 0;
  int readToDone;

  always #5 clk = ~clk;

  assign rd_data = regs[rd_addr];

  regfile_dump dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .first_addr (first_addr),
    .last_addr  (last_addr),
    .hold_req   (hold_req),
    .hold_ack   (hold_ack),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_addr   (out_addr),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done)
  );

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [DATA_W-1:0] observed,
                             input logic [DATA_W-1:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [ADDR_W-1:0] first, input logic [ADDR_W-1:0] last);
    first_addr = first;
    last_addr  = last;
    start      = 1'b1;
    cycle();
    start      = 1'b0;
  endtask

  // Collects words with out_ready high until done; entered with hold_ack already high.
  task automatic drainDump(input logic [ADDR_W-1:0] first, input int expCount,
                           output int cyclesFromRead);
    int got;
    int budget;
    logic [ADDR_W-1:0] a;
    got    = 0;
    budget = 0;
    a      = first;
    while (done !== 1'b1 && budget < 200) begin
      if (out_valid && out_ready) begin
        checkOutput("wordAddr", DATA_W'(out_addr), DATA_W'(a));
        checkOutput("wordData", out_data, regs[a]);
        checkOutput("wordLast", DATA_W'(out_last), DATA_W'(got == expCount - 1));
        got++;
        a = a + ADDR_W'(1);
      end
      cycle();
      budget++;
    end
    cyclesFromRead = budget - 1;
    checkOutput("doneSeen", DATA_W'(done), 32'd1);
    checkOutput("holdReqInDone", DATA_W'(hold_req), 32'd0);
    checkOutput("wordCount", DATA_W'(got), DATA_W'(expCount));
    cycle();
    checkOutput("donePulseOneCycle", DATA_W'(done), 32'd0);
    checkOutput("idleAfterDone", DATA_W'(busy), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'h5A00_0000 + 32'(i) * 32'h0001_0101;
    regs[0] = 32'h0;
    regs[3] = 32'h0000_000A;
    regs[4] = 32'hFFFF_FF0B;
    regs[5] = 32'h0000_000C;

    reset = 1'b0; start = 1'b0; abort = 1'b0; hold_ack = 1'b0; out_ready = 1'b1;
    first_addr = '0; last_addr = '0;
    cycle();
    cycle();
    checkOutput("resetBusy", DATA_W'(busy), 32'd0);
    checkOutput("resetHoldReq", DATA_W'(hold_req), 32'd0);
    checkOutput("resetValid", DATA_W'(out_valid), 32'd0);
    reset = 1'b1;
    cycle();

    // Basic range 3..5 with hold_ack arriving two cycles after hold_req.
    applyStimulus(5'd3, 5'd5);
    checkOutput("holdReqRaised", DATA_W'(hold_req), 32'd1);
    cycle();
    cycle();
    checkOutput("waitingInHold", DATA_W'(out_valid), 32'd0);
    hold_ack = 1'b1;
    drainDump(5'd3, 3, readToDone);
    checkOutput("basicCycles", DATA_W'(readToDone), 32'd6);
    hold_ack = 1'b0;

    // Wrap through x31 to x0.
    applyStimulus(5'd30, 5'd1);
    hold_ack = 1'b1;
    drainDump(5'd30, 4, readToDone);
    hold_ack = 1'b0;

    // Backpressure on the second word of 3..5.
    applyStimulus(5'd3, 5'd5);
    hold_ack = 1'b1;
    cycle();
    hold_ack = 1'b0;
    cycle();
    checkOutput("bpWord0Addr", DATA_W'(out_addr), 32'd3);
    cycle();
    out_ready = 1'b0;
    cycle();
    for (int i = 0; i < 5; i++) begin
      checkOutput("bpValid", DATA_W'(out_valid), 32'd1);
      checkOutput("bpAddr", DATA_W'(out_addr), 32'd4);
      checkOutput("bpData", out_data, 32'hFFFF_FF0B);
      cycle();
    end
    out_ready = 1'b1;
    checkOutput("bpWord1Held", DATA_W'(out_addr), 32'd4);
    cycle();
    cycle();
    checkOutput("bpWord2Addr", DATA_W'(out_addr), 32'd5);
    checkOutput("bpWord2Last", DATA_W'(out_last), 32'd1);
    cycle();
    checkOutput("bpDone", DATA_W'(done), 32'd1);
    cycle();

    // Full 32-word dump.
    applyStimulus(5'd0, 5'd31);
    hold_ack = 1'b1;
    drainDump(5'd0, 32, readToDone);
    checkOutput("fullCycles", DATA_W'(readToDone), 32'd64);
    hold_ack = 1'b0;

    // Abort while the second word is presented.
    applyStimulus(5'd10, 5'd15);
    hold_ack = 1'b1;
    cycle();
    hold_ack = 1'b0;
    cycle();
    cycle();
    cycle();
    checkOutput("abortWord2Addr", DATA_W'(out_addr), 32'd11);
    checkOutput("abortWord2Valid", DATA_W'(out_valid), 32'd1);
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    checkOutput("abortIdle", DATA_W'(busy), 32'd0);
    checkOutput("abortHoldReq", DATA_W'(hold_req), 32'd0);
    checkOutput("abortValid", DATA_W'(out_valid), 32'd0);
    checkOutput("abortLast", DATA_W'(out_last), 32'd0);
    checkOutput("abortNoDone", DATA_W'(done), 32'd0);
    cycle();
    checkOutput("abortNoDoneLater", DATA_W'(done), 32'd0);

    // Start pulsed while busy is ignored.
    applyStimulus(5'd20, 5'd21);
    hold_ack   = 1'b1;
    first_addr = 5'd2;
    last_addr  = 5'd2;
    start      = 1'b1;
    cycle();
    start = 1'b0;
    drainDump(5'd20, 2, readToDone);
    checkOutput("noQueuedStart", DATA_W'(busy), 32'd0);
    hold_ack = 1'b0;

    // Single-word range.
    applyStimulus(5'd7, 5'd7);
    hold_ack = 1'b1;
    drainDump(5'd7, 1, readToDone);
    hold_ack = 1'b0;

    // Start and abort together in IDLE: abort wins.
    first_addr = 5'd1;
    last_addr  = 5'd2;
    start = 1'b1;
    abort = 1'b1;
    cycle();
    start = 1'b0;
    abort = 1'b0;
    checkOutput("startAbortIdle", DATA_W'(busy), 32'd0);

    // Reset mid-dump with a word presented.
    applyStimulus(5'd8, 5'd12);
    hold_ack  = 1'b1;
    out_ready = 1'b0;
    cycle();
    hold_ack = 1'b0;
    cycle();
    checkOutput("preResetValid", DATA_W'(out_valid), 32'd1);
    reset = 1'b0;
    cycle();
    checkOutput("rstHoldReq", DATA_W'(hold_req), 32'd0);
    checkOutput("rstRdAddr", DATA_W'(rd_addr), 32'd0);
    checkOutput("rstValid", DATA_W'(out_valid), 32'd0);
    checkOutput("rstOutAddr", DATA_W'(out_addr), 32'd0);
    checkOutput("rstOutData", out_data, 32'd0);
    checkOutput("rstOutLast", DATA_W'(out_last), 32'd0);
    checkOutput("rstBusy", DATA_W'(busy), 32'd0);
    checkOutput("rstDone", DATA_W'(done), 32'd0);
    reset     = 1'b1;
    out_ready = 1'b1;
    cycle();

    // No hold_ack: the block waits in HOLD indefinitely.
    applyStimulus(5'd0, 5'd3);
    for (int i = 0; i < 20; i++) cycle();
    checkOutput("stuckBusy", DATA_W'(busy), 32'd1);
    checkOutput("stuckHoldReq", DATA_W'(hold_req), 32'd1);
    checkOutput("stuckValid", DATA_W'(out_valid), 32'd0);
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    checkOutput("abortFromHold", DATA_W'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
